// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct constants, ALU codes, FSM state encoding and mux selects
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_SRL  = 4'b1100;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
    localparam logic [1:0] SA_PC = 2'b00, SA_A = 2'b01, SA_SHAMT = 2'b10;
    localparam logic [1:0] SB_B = 2'b00, SB_FOUR = 2'b01, SB_IMM = 2'b10, SB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_A = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_WB_MEM   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_HALT     = 4'd15
    } state_t;

    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        return fn == FN_ADD ? ALU_ADD :
               fn == FN_SUB ? ALU_SUB :
               fn == FN_AND ? ALU_AND :
               fn == FN_OR  ? ALU_OR  :
               fn == FN_SLT ? ALU_SLT :
               fn == FN_SLL ? ALU_SLL :
               fn == FN_SRL ? ALU_SRL : ALU_NONE;
    endfunction

    // Unsupported encodings map to S_FETCH; the caller treats that as illegal.
    function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return fn == FN_JR ? S_JR :
                             funct_alu(fn) != ALU_NONE ? S_EXEC_R : S_FETCH;
            OP_ADDI: return S_EXEC_I;
            OP_LW, OP_SW: return S_MEM_ADDR;
            OP_BEQ, OP_BNE: return S_BRANCH;
            OP_J: return S_JUMP;
            OP_JAL: return S_JAL;
            default: return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control/status bundle between the sequencer and the datapath
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_instr;
    logic       mem_timeout;
    logic [3:0] state;

    modport master (
        input  opcode, funct, alu_zero, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_ctrl, pc_source, instr_done, illegal_instr, mem_timeout, state
    );

    modport slave (
        output opcode, funct, alu_zero, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, alu_ctrl, pc_source, instr_done, illegal_instr, mem_timeout, state
    );
endinterface

// File: rtl/multicycle_control_mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready cycles of a memory access and flags a timeout
module mem_wait_timer #(
    parameter int unsigned MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    output logic timeout,
    output logic mem_timeout
);
    localparam int W = MAX > 0 ? $clog2(MAX + 1) : 1;

    logic [W-1:0] cnt;

    assign timeout = MAX != 0 && waiting && cnt == W'(MAX);

    // Leaving the wait (ready or timeout) is always a state change, so the count restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            mem_timeout <= 1'b0;
        end else begin
            cnt         <= (waiting && !timeout) ? cnt + 1'b1 : '0;
            mem_timeout <= mem_timeout | timeout;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle MIPS core
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    multicycle_control_if.master   bus
);
    state_t state;
    state_t next;
    state_t dec;
    logic   waiting;
    logic   timeout;

    assign dec     = decode_next(bus.opcode, bus.funct);
    assign waiting = (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !bus.mem_ready;
    assign bus.state = state;

    mem_wait_timer #(.MAX(MEM_WAIT_MAX)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .waiting     (waiting),
        .timeout     (timeout),
        .mem_timeout (bus.mem_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next;
    end

    always_comb begin
        next = S_FETCH;
        case (state)
            S_FETCH:    next = timeout ? S_HALT : bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:   next = dec;
            S_MEM_ADDR: next = bus.opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   next = timeout ? S_HALT : bus.mem_ready ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR:   next = timeout ? S_HALT : bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:   next = S_WB_R;
            S_EXEC_I:   next = S_WB_I;
            S_HALT:     next = S_HALT;
            default:    next = S_FETCH;
        endcase
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.ir_write      = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = RD_RT;
        bus.mem_to_reg    = M2R_ALU;
        bus.alu_src_a     = SA_PC;
        bus.alu_src_b     = SB_B;
        bus.alu_ctrl      = ALU_NONE;
        bus.pc_source     = PCS_ALU;
        bus.instr_done    = 1'b0;
        bus.illegal_instr = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SB_FOUR;
                bus.alu_ctrl  = ALU_ADD;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
            end
            S_DECODE: begin
                bus.alu_src_b     = SB_IMM_SH2;
                bus.alu_ctrl      = ALU_ADD;
                bus.illegal_instr = dec == S_FETCH;
                bus.instr_done    = dec == S_FETCH;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                bus.alu_src_a = SA_A;
                bus.alu_src_b = SB_IMM;
                bus.alu_ctrl  = ALU_ADD;
            end
            S_MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = M2R_MDR;
                bus.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.i_or_d     = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            S_EXEC_R: begin
                bus.alu_src_a = (bus.funct == FN_SLL || bus.funct == FN_SRL) ? SA_SHAMT : SA_A;
                bus.alu_ctrl  = funct_alu(bus.funct);
            end
            S_WB_R: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = RD_RD;
                bus.instr_done = 1'b1;
            end
            S_WB_I: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a  = SA_A;
                bus.alu_ctrl   = ALU_SUB;
                bus.pc_source  = PCS_ALUOUT;
                bus.pc_write   = bus.opcode[0] ? !bus.alu_zero : bus.alu_zero;
                bus.instr_done = 1'b1;
            end
            S_JUMP: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCS_JUMP;
                bus.instr_done = 1'b1;
            end
            S_JAL: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCS_JUMP;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = RD_RA;
                bus.mem_to_reg = M2R_PC;
                bus.instr_done = 1'b1;
            end
            S_JR: begin
                bus.pc_write   = 1'b1;
                bus.pc_source  = PCS_A;
                bus.instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset abandons whatever is in flight: no write or pulse escapes.
        if (rst) begin
            bus.pc_write      = 1'b0;
            bus.ir_write      = 1'b0;
            bus.mem_read      = 1'b0;
            bus.mem_write     = 1'b0;
            bus.reg_write     = 1'b0;
            bus.instr_done    = 1'b0;
            bus.illegal_instr = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized instruction streams against a per-instruction step model
module tb_multicycle_control;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control #(.MEM_WAIT_MAX(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       pcw, irw, iod, mr, mw, rw;
        logic [1:0] rd, m2r, sa, sb;
        logic [3:0] alu;
        logic [1:0] pcs;
        logic       done, ill;
    } ctl_t;

    int   pass_n = 0;
    int   total_n = 0;
    logic exp_to = 1'b0;

    logic [5:0] rnd_ops [11] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};
    logic [5:0] rnd_fns [9]  = '{6'h00, 6'h02, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h08, 6'h3f};

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return fn inside {6'h00, 6'h02, 6'h08, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
        return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h23, 6'h2b};
    endfunction

    function automatic logic [3:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return 4'b0010;
            6'h22: return 4'b0110;
            6'h24: return 4'b0000;
            6'h25: return 4'b0001;
            6'h2a: return 4'b0111;
            6'h00: return 4'b1010;
            6'h02: return 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    // Expected control word for one cycle spent in state st, straight from the per-state output table.
    function automatic ctl_t exp_ctl(input int st, input logic [5:0] op, input logic [5:0] fn,
                                     input logic z, input logic rdy, input logic r);
        ctl_t c;
        c = '0;
        c.alu = 4'hf;
        case (st)
            0:  begin c.mr = 1; c.sb = 2'b01; c.alu = 4'b0010; c.irw = rdy; c.pcw = rdy; end
            1:  begin c.sb = 2'b11; c.alu = 4'b0010; c.ill = !legal(op, fn); c.done = !legal(op, fn); end
            2:  begin c.sa = 2'b01; c.sb = 2'b10; c.alu = 4'b0010; end
            3:  begin c.mr = 1; c.iod = 1; end
            4:  begin c.rw = 1; c.m2r = 2'b01; c.done = 1; end
            5:  begin c.mw = 1; c.iod = 1; c.done = rdy; end
            6:  begin c.alu = r_alu(fn); c.sa = (fn == 6'h00 || fn == 6'h02) ? 2'b10 : 2'b01; end
            7:  begin c.rw = 1; c.rd = 2'b01; c.done = 1; end
            8:  begin c.sa = 2'b01; c.sb = 2'b10; c.alu = 4'b0010; end
            9:  begin c.rw = 1; c.done = 1; end
            10: begin c.sa = 2'b01; c.alu = 4'b0110; c.pcs = 2'b01; c.pcw = op[0] ? !z : z; c.done = 1; end
            11: begin c.pcw = 1; c.pcs = 2'b10; c.done = 1; end
            12: begin c.pcw = 1; c.pcs = 2'b10; c.rw = 1; c.rd = 2'b10; c.m2r = 2'b10; c.done = 1; end
            13: begin c.pcw = 1; c.pcs = 2'b11; c.done = 1; end
            default: ;
        endcase
        if (r) {c.pcw, c.irw, c.mr, c.mw, c.rw, c.done, c.ill} = '0;
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_n++;
        assert (got === exp) pass_n++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic cycle(input int st, input string tag);
        ctl_t got;
        @(negedge clk);
        got = {bus.pc_write, bus.ir_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.reg_write,
               bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl, bus.pc_source,
               bus.instr_done, bus.illegal_instr};
        chk({tag, "/state"}, 32'(bus.state), 32'(st));
        chk({tag, "/ctl"}, 32'(got), 32'(exp_ctl(st, bus.opcode, bus.funct, bus.alu_zero, bus.mem_ready, rst)));
        chk({tag, "/timeout"}, 32'(bus.mem_timeout), 32'(exp_to));
        @(posedge clk);
        #1;
    endtask

    // Step list for one instruction; wf/wm are the not-ready cycles inserted before the fetch/memory completes.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int wf, input int wm, input string tag);
        int p[5];
        int n;
        int w;
        p = '{0, 1, 0, 0, 0};
        n = 2;
        if (legal(op, fn)) begin
            if (op == 6'h00) begin p = fn == 6'h08 ? '{0, 1, 13, 0, 0} : '{0, 1, 6, 7, 0}; n = fn == 6'h08 ? 3 : 4; end
            else if (op == 6'h08) begin p = '{0, 1, 8, 9, 0}; n = 4; end
            else if (op == 6'h23) begin p = '{0, 1, 2, 3, 4}; n = 5; end
            else if (op == 6'h2b) begin p = '{0, 1, 2, 5, 0}; n = 4; end
            else if (op == 6'h02) begin p = '{0, 1, 11, 0, 0}; n = 3; end
            else if (op == 6'h03) begin p = '{0, 1, 12, 0, 0}; n = 3; end
            else begin p = '{0, 1, 10, 0, 0}; n = 3; end
        end
        bus.opcode = op;
        bus.funct = fn;
        bus.alu_zero = z;
        for (int i = 0; i < n; i++) begin
            w = p[i] == 0 ? wf : (p[i] == 3 || p[i] == 5) ? wm : 0;
            for (int k = 0; k <= w; k++) begin
                bus.mem_ready = (p[i] == 0 || p[i] == 3 || p[i] == 5) ? (k == w) : 1'($urandom);
                cycle(p[i], tag);
            end
        end
    endtask

    initial begin
        bus.opcode = 6'h00;
        bus.funct = 6'h20;
        bus.alu_zero = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        cycle(0, "reset");
        rst = 1'b0;

        run_instr(6'h00, 6'h20, 0, 0, 0, "add");
        run_instr(6'h23, 6'h00, 0, 0, 3, "lw_wait");
        run_instr(6'h04, 6'h00, 1, 0, 0, "beq_taken");
        run_instr(6'h05, 6'h00, 1, 0, 0, "bne_not_taken");
        run_instr(6'h05, 6'h00, 0, 0, 0, "bne_taken");
        run_instr(6'h03, 6'h00, 0, 0, 0, "jal");
        run_instr(6'h3f, 6'h00, 0, 0, 0, "illegal_op");
        run_instr(6'h00, 6'h3f, 0, 0, 0, "illegal_funct");
        run_instr(6'h00, 6'h08, 0, 0, 0, "jr");
        run_instr(6'h02, 6'h00, 0, 2, 0, "j_fetch_wait");
        run_instr(6'h2b, 6'h00, 0, 0, 2, "sw_wait");
        run_instr(6'h08, 6'h00, 0, 0, 0, "addi");
        run_instr(6'h00, 6'h00, 0, 0, 0, "sll");
        run_instr(6'h00, 6'h02, 0, 0, 0, "srl");
        run_instr(6'h00, 6'h22, 0, 0, 0, "sub");
        run_instr(6'h00, 6'h24, 0, 0, 0, "and");
        run_instr(6'h00, 6'h25, 0, 0, 0, "or");
        run_instr(6'h00, 6'h2a, 0, 0, 0, "slt");
        run_instr(6'h02, 6'h00, 0, 15, 0, "fetch_ready_at_limit");
        run_instr(6'h23, 6'h00, 0, 0, 15, "mem_ready_at_limit");

        for (int i = 0; i < 40; i++) begin
            run_instr(rnd_ops[$urandom_range(0, 10)], rnd_fns[$urandom_range(0, 8)], 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), "random");
        end

        bus.opcode = 6'h00;
        bus.funct = 6'h20;
        bus.mem_ready = 1'b1;
        cycle(0, "mid_fetch");
        cycle(1, "mid_decode");
        cycle(6, "mid_exec");
        rst = 1'b1;
        cycle(7, "mid_wb_reset");
        rst = 1'b0;
        run_instr(6'h04, 6'h00, 1, 0, 0, "after_mid_reset");

        bus.opcode = 6'h02;
        bus.mem_ready = 1'b0;
        for (int k = 0; k < 16; k++) cycle(0, "fetch_stuck");
        exp_to = 1'b1;
        bus.mem_ready = 1'b1;
        cycle(15, "halt");
        cycle(15, "halt_hold");
        rst = 1'b1;
        cycle(15, "halt_reset");
        exp_to = 1'b0;
        cycle(0, "reset_fetch");
        rst = 1'b0;
        run_instr(6'h00, 6'h20, 0, 0, 0, "after_halt");

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
